// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares one memory port between D-cache write-through, D-fill and I-fill.
// Define ARB_ROUND_ROBIN_EN to alternate contended I/D fills; otherwise D-fill always wins.
module cache_fill_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_miss,
  input  logic [15:0] icache_miss_addr,
  input  logic        dcache_miss,
  input  logic [15:0] dcache_miss_addr,
  input  logic        dcache_wr,
  input  logic [15:0] dcache_wr_addr,
  input  logic [15:0] dcache_wr_data,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        icache_fill_we,
  output logic        dcache_fill_we,
  output logic        icache_fill_done,
  output logic        dcache_fill_done,
  output logic        wr_ack
);
  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;
  state_t state;
  logic [3:0] issue_cnt, recv_cnt;
  logic [15:0] base;
  logic fill, issuing, rx, last_word, grant_d;
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("MEM_LATENCY must be at least 1");
  end
`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
  assign grant_d = dcache_miss && (!icache_miss || !last_grant);
`else
  assign grant_d = dcache_miss;
`endif
  // every output is forced low while rst is high, so an aborted operation never pulses
  assign fill = state == FILL_I || state == FILL_D;
  assign issuing = !rst && fill && issue_cnt < 4'(BLOCK_WORDS);
  assign rx = !rst && fill && mem_data_valid;
  assign last_word = rx && recv_cnt == 4'(BLOCK_WORDS - 1);
  assign wr_ack = !rst && state == WRITE;
  assign mem_wr = wr_ack;
  assign mem_en = wr_ack || issuing;
  assign mem_addr = wr_ack ? dcache_wr_addr : issuing ? base + (16'(issue_cnt) << 1) : '0;
  assign mem_data_in = wr_ack ? dcache_wr_data : '0;
  assign fill_data = rx ? mem_data_out : '0;
  assign fill_word = rx ? recv_cnt[2:0] : '0;
  assign icache_fill_we = rx && state == FILL_I;
  assign dcache_fill_we = rx && state == FILL_D;
  assign icache_fill_done = last_word && state == FILL_I;
  assign dcache_fill_done = last_word && state == FILL_D;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      issue_cnt <= '0;
      recv_cnt <= '0;
      base <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (dcache_wr) state <= WRITE;
          else if (dcache_miss || icache_miss) begin
            state <= grant_d ? FILL_D : FILL_I;
            base <= (grant_d ? dcache_miss_addr : icache_miss_addr) & 16'hFFF0;
            issue_cnt <= '0;
            recv_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= grant_d;
`endif
          end
        end
        WRITE: state <= IDLE;
        default: begin
          if (issuing) issue_cnt <= issue_cnt + 4'd1;
          if (rx) recv_cnt <= recv_cnt + 4'd1;
          if (last_word) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: randomized requesters and a latency memory against a transaction-level arbitration model.
module tb_cache_fill_arbiter;
  localparam int LAT = 4;
  logic clk = 1'b0, rst;
  logic icache_miss, dcache_miss, dcache_wr, mv, spur;
  logic [15:0] icache_miss_addr, dcache_miss_addr, dcache_wr_addr, dcache_wr_data, mem_data_out;
  logic mem_en, mem_wr, icache_fill_we, dcache_fill_we, icache_fill_done, dcache_fill_done, wr_ack;
  logic [15:0] mem_addr, mem_data_in, fill_data;
  logic [2:0] fill_word;
  logic mem_data_valid;
  assign mem_data_valid = mv | spur;
  always #5 clk = ~clk;

  cache_fill_arbiter #(.MEM_LATENCY(LAT), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .dcache_wr(dcache_wr), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .fill_data(fill_data), .fill_word(fill_word),
    .icache_fill_we(icache_fill_we), .dcache_fill_we(dcache_fill_we),
    .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done), .wr_ack(wr_ack)
  );

  typedef struct {int due; logic [15:0] addr;} rd_t;
  typedef struct {logic wr; logic [15:0] addr; logic [15:0] data; int k;} mop_t;
  typedef struct {logic d; int k; logic [15:0] data;} fop_t;
  typedef struct {logic [15:0] addr; logic [15:0] data;} req_t;
  rd_t pend[$];
  mop_t exp_mem[$];
  fop_t exp_fill[$];
  req_t w_q[$], d_q[$], i_q[$], sw[$], sd[$], si[$];
  int cyc = 0, checks = 0, errors = 0, nfill = 0, t_first = 0;
  logic got_i = 0, got_d = 0, got_w = 0, prev_end = 0, last_d = 0;
  logic [63:0] outs;
  assign outs = {mem_en, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
                 icache_fill_we, dcache_fill_we, icache_fill_done, dcache_fill_done, wr_ack};

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // requesters hold each request until its ack/done, then present the next one; memory returns reads after LAT cycles
  initial begin
    {icache_miss, dcache_miss, dcache_wr, mv} = '0;
    {icache_miss_addr, dcache_miss_addr, dcache_wr_addr, dcache_wr_data, mem_data_out} = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (got_i && i_q.size() > 0) void'(i_q.pop_front());
      if (got_d && d_q.size() > 0) void'(d_q.pop_front());
      if (got_w && w_q.size() > 0) void'(w_q.pop_front());
      icache_miss = i_q.size() > 0;
      icache_miss_addr = i_q.size() > 0 ? i_q[0].addr : 16'h0;
      dcache_miss = d_q.size() > 0;
      dcache_miss_addr = d_q.size() > 0 ? d_q[0].addr : 16'h0;
      dcache_wr = w_q.size() > 0;
      dcache_wr_addr = w_q.size() > 0 ? w_q[0].addr : 16'h0;
      dcache_wr_data = w_q.size() > 0 ? w_q[0].data : 16'h0;
      mv = 1'b0;
      mem_data_out = 16'h0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        mv = 1'b1;
        mem_data_out = mem_val(pend[0].addr);
        void'(pend.pop_front());
      end
    end
  end

  // monitor: every memory access and every fill write is matched against the scoreboard
  initial forever begin
    mop_t m;
    fop_t f;
    @(negedge clk);
    got_i = icache_fill_done;
    got_d = dcache_fill_done;
    got_w = wr_ack;
    if (prev_end) chk("idle_gap_mem_en", mem_en, 0);
    prev_end = wr_ack | icache_fill_done | dcache_fill_done;
    if (mem_en && !mem_wr) pend.push_back(rd_t'{cyc + LAT, mem_addr});
    if (mem_en) begin
      if (exp_mem.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_access: got unexpected access addr %h wr %b expected none", mem_addr, mem_wr);
      end else begin
        m = exp_mem.pop_front();
        chk("mem_wr", mem_wr, m.wr);
        chk("mem_addr", mem_addr, m.addr);
        chk("wr_ack", wr_ack, m.wr);
        if (m.wr) chk("mem_data_in", mem_data_in, m.data);
        else if (m.k == 0) t_first = cyc;
        else chk("read_cycle", cyc, t_first + m.k);
      end
    end else chk("wr_ack_no_access", wr_ack, 0);
    if (icache_fill_we || dcache_fill_we) begin
      if (exp_fill.size() == 0) begin
        checks++; errors++;
        $display("FAIL fill_write: got unexpected fill word %0d expected none", fill_word);
      end else begin
        f = exp_fill.pop_front();
        chk("fill_owner", {icache_fill_we, dcache_fill_we}, f.d ? 2'b01 : 2'b10);
        chk("fill_word", fill_word, f.k);
        chk("fill_data", fill_data, f.data);
        chk("fill_done", {icache_fill_done, dcache_fill_done}, f.k != 7 ? 2'b00 : f.d ? 2'b01 : 2'b10);
        if (f.k == 7) chk("done_latency", cyc - t_first, 7 + LAT);
        nfill++;
      end
    end else chk("done_without_we", {icache_fill_done, dcache_fill_done}, 0);
  end

  task automatic add_w(input logic [15:0] a, input logic [15:0] d);
    sw.push_back(req_t'{a, d});
  endtask
  task automatic add_d(input logic [15:0] a);
    sd.push_back(req_t'{a, 16'h0});
  endtask
  task automatic add_i(input logic [15:0] a);
    si.push_back(req_t'{a, 16'h0});
  endtask

  // reference: with every requester continuously pending, grants follow write > fill policy order
  task automatic launch();
    req_t tw[$] = sw;
    req_t td[$] = sd;
    req_t ti[$] = si;
    req_t r;
    logic pick_d;
    logic [15:0] b;
    while (tw.size() > 0 || td.size() > 0 || ti.size() > 0) begin
      if (tw.size() > 0) begin
        r = tw.pop_front();
        exp_mem.push_back(mop_t'{1'b1, r.addr, r.data, 0});
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = td.size() > 0 && (ti.size() == 0 || !last_d);
`else
        pick_d = td.size() > 0;
`endif
        if (pick_d) r = td.pop_front();
        else r = ti.pop_front();
        last_d = pick_d;
        b = r.addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
          exp_mem.push_back(mop_t'{1'b0, b + 16'(2 * k), 16'h0, k});
          exp_fill.push_back(fop_t'{pick_d, k, mem_val(b + 16'(2 * k))});
        end
      end
    end
    foreach (sw[j]) w_q.push_back(sw[j]);
    foreach (sd[j]) d_q.push_back(sd[j]);
    foreach (si[j]) i_q.push_back(si[j]);
    sw.delete(); sd.delete(); si.delete();
  endtask

  task automatic drop_all();
    exp_mem.delete(); exp_fill.delete();
    w_q.delete(); d_q.delete(); i_q.delete();
    {icache_miss, dcache_miss, dcache_wr} = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_mem.size() > 0 || exp_fill.size() > 0 || w_q.size() > 0 || d_q.size() > 0 ||
            i_q.size() > 0 || pend.size() > 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending accesses expected 0", exp_mem.size());
      drop_all();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n0, stray, guard;
    rst = 1'b1;
    spur = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_d = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", outs, 0);
    @(posedge clk); #1;
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spurious_valid_idle", outs, 0);
      @(posedge clk); #1;
    end
    spur = 1'b0;
    add_i(16'h1236);
    launch();
    wait_idle();
    add_w(16'h0040, 16'hBEEF);
    add_d(16'h0047);
    launch();
    wait_idle();
    add_d(16'h2000); add_d(16'h3008);
    add_i(16'h4010); add_i(16'h501F);
    launch();
    wait_idle();
    // abort a fill by reset right after its third word
    n0 = nfill;
    add_i(16'h7ABC);
    launch();
    guard = 0;
    do begin @(posedge clk); guard++; end while (nfill < n0 + 3 && guard < 200);
    chk("words_before_reset", nfill - n0, 3);
    #1;
    rst = 1'b1;
    last_d = 1'b0;
    drop_all();
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      stray += int'(mem_data_valid);
      chk("after_abort_quiet", outs, 0);
    end
    chk("stray_returns_seen", stray > 0, 1);
    wait_idle();
    for (int s = 0; s < 25; s++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) add_w(16'($urandom), 16'($urandom));
      for (int j = $urandom_range(0, 3); j > 0; j--) add_d(16'($urandom));
      for (int j = $urandom_range(0, 3); j > 0; j--) add_i(16'($urandom));
      launch();
      wait_idle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_fill_arbiter.md
CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, cycles from read issue to mem_data_valid in the bench memory model; RTL behaviour SHALL NOT depend on it.
REQ-002 SHALL have parameter BLOCK_WORDS, default 8, 16-bit words per cache block; block = 16 bytes.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 icache_miss  in  1  I-cache block fill request, level, held until icache_fill_done.
REQ-007 icache_miss_addr  in  16  byte address of the missing I-cache access.
REQ-008 dcache_miss  in  1  D-cache block fill request, level, held until dcache_fill_done.
REQ-009 dcache_miss_addr  in  16  byte address of the missing D-cache access.
REQ-010 dcache_wr  in  1  write-through request, level, held until wr_ack.
REQ-011 dcache_wr_addr  in  16  write byte address.
REQ-012 dcache_wr_data  in  16  write data.
REQ-013 mem_data_out  in  16  read data from main memory.
REQ-014 mem_data_valid  in  1  mem_data_out valid this cycle.
REQ-015 mem_en  out  1  memory access strobe.
REQ-016 mem_wr  out  1  1 = write, 0 = read; valid only with mem_en.
REQ-017 mem_addr  out  16  memory byte address.
REQ-018 mem_data_in  out  16  memory write data (= dcache_wr_data).
REQ-019 fill_data  out  16  = mem_data_out.
REQ-020 fill_word  out  3  index of the word being written into the cache block.
REQ-021 icache_fill_we  out  1  write fill_data into the I-cache.
REQ-022 dcache_fill_we  out  1  write fill_data into the D-cache.
REQ-023 icache_fill_done  out  1  one-cycle pulse, I-cache fill complete.
REQ-024 dcache_fill_done  out  1  one-cycle pulse, D-cache fill complete.
REQ-025 wr_ack  out  1  one-cycle pulse, write issued.

Function
REQ-026 SHALL implement the FSM states IDLE, WRITE, FILL_I and FILL_D; all outputs SHALL decode from registered state and counters, except the fill strobes, which SHALL be gated by mem_data_valid.
REQ-027 IDLE SHALL grant in this priority order: dcache_wr -> WRITE; dcache_miss -> FILL_D; icache_miss -> FILL_I. With no request, the FSM SHALL stay in IDLE. In IDLE, mem_en = 0.
REQ-028 WRITE SHALL last exactly 1 cycle with mem_en = 1, mem_wr = 1, mem_addr = dcache_wr_addr, wr_ack = 1; next state SHALL be IDLE.
REQ-029 On entry to a FILL state, the block SHALL latch base = miss_addr & 16'hFFF0 and clear issue_cnt and recv_cnt (both 4-bit).
REQ-030 In a FILL state, while issue_cnt < 8: mem_en = 1, mem_wr = 0, mem_addr = base + 2*issue_cnt, and issue_cnt SHALL increment every cycle (8 back-to-back reads).
REQ-031 In a FILL state, each mem_data_valid cycle: fill_word = recv_cnt[2:0], the owning cache's fill_we = 1, and recv_cnt SHALL increment.
REQ-032 The 8th valid word SHALL assert the owner's fill_done in that same cycle; next state SHALL be IDLE.
REQ-033 mem_data_valid in IDLE or WRITE SHALL be ignored: no fill_we and no counter change.
REQ-034 Requests arriving during a fill or write SHALL wait; the arbiter SHALL return to IDLE for at least 1 cycle between grants.
REQ-035 A requester's request input SHALL NOT be sampled again while it is being serviced; a changed address mid-fill SHALL be ignored.

Reset
REQ-036 rst SHALL force state = IDLE, counters = 0, base = 0, and the round-robin pointer = I.
REQ-037 Every output SHALL be 0 during and after reset until a grant.
REQ-038 Reset mid-fill or mid-write SHALL abort the operation with no done or ack pulse; in-flight memory returns after reset SHALL be ignored.

Configuration
REQ-039 ARB_ROUND_ROBIN_EN defined: when dcache_miss and icache_miss are both pending in IDLE (no dcache_wr), the block SHALL grant the cache not granted last; a 1-bit last_grant flop SHALL update on each fill grant.
REQ-040 ARB_ROUND_ROBIN_EN undefined: dcache_miss SHALL always win over icache_miss; the last_grant flop SHALL NOT exist.
REQ-041 dcache_wr SHALL have top priority in both configurations.

Verification
REQ-042 The bench SHALL cover: icache_miss=1, addr 0x1236, 4-cycle memory -> reads 0x1230..0x123E on 8 consecutive cycles; fill_word 0..7; icache_fill_done pulses 11 cycles after the first mem_en.
REQ-043 The bench SHALL cover: dcache_wr (0x0040, 0xBEEF) and dcache_miss together in IDLE -> 1 write cycle with wr_ack; IDLE; then FILL_D at base 0x0040.
REQ-044 The bench SHALL cover: both misses held, no round-robin -> D filled, then D again if still requesting; with ARB_ROUND_ROBIN_EN -> D, then I, alternating.
REQ-045 The bench SHALL cover: rst asserted after the 3rd fill word -> no done pulse, IDLE next cycle, stray mem_data_valid produces no fill_we.
REQ-046 The bench SHALL cover: spurious mem_data_valid in IDLE -> all outputs remain 0.
